// File: rtl/mxv_lane_scheduler_if.sv
// Output handshake bundle for mxv_lane_scheduler.
//   out_valid    : out_data/out_row_idx hold a complete group
//   out_ready    : consumer accepts the current group
//   out_data     : packed lane results, lane k in [(k+1)*ELEM_W-1 -: ELEM_W]
//   out_row_idx  : row index of lane 0 in out_data
// master = scheduler side, slave = consumer side.
interface mxv_lane_scheduler_if #(
   parameter int unsigned ELEM_W    = 32,
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned CNT_W     = 32
) ();
   logic                        out_valid;
   logic                        out_ready;
   logic [NUM_LANES*ELEM_W-1:0] out_data;
   logic [CNT_W-1:0]            out_row_idx;

   modport master (output out_valid, output out_data, output out_row_idx, input out_ready);
   modport slave  (input out_valid, input out_data, input out_row_idx, output out_ready);
endinterface

// File: rtl/mxv_lane_scheduler.sv
// Matrix-by-vector lane scheduler. Walks total_rows in groups of NUM_LANES,
// requests operands per group, pulses the active lanes, collects their
// results and presents one packed word per group over a valid/ready port.
//
// Ports:
//   clk, reset (async, active low)
//   start            : level run enable, low aborts to IDLE
//   total_rows       : rows to process, sampled when leaving IDLE
//   no_of_multiples  : per-row pass count, sampled with total_rows
//   lane_multiples   : registered copy of sampled no_of_multiples
//   mem_fetch        : one-cycle operand request per group
//   mem_ready        : operands valid (observed in WAIT_MEM only)
//   lane_start       : one-cycle start pulse per active lane
//   lane_done        : per-lane completion pulse
//   lane_result      : per-lane result, lane k at [(k+1)*ELEM_W-1 -: ELEM_W]
//   out_if           : out_valid/out_ready/out_data/out_row_idx (master)
//   busy             : not in IDLE or DONE
//   finish           : all groups delivered (held while start=1)
//
// Optional build macro MXV_PROTOCOL_CHK_EN adds proto_err, a sticky flag for
// stray lane_done / mem_ready activity; cleared by reset or entering IDLE.
module mxv_lane_scheduler #(
   parameter int unsigned ELEM_W    = 32,
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [CNT_W-1:0]            total_rows,
   input  logic [CNT_W-1:0]            no_of_multiples,
   output logic [CNT_W-1:0]            lane_multiples,
   output logic                        mem_fetch,
   input  logic                        mem_ready,
   output logic [NUM_LANES-1:0]        lane_start,
   input  logic [NUM_LANES-1:0]        lane_done,
   input  logic [NUM_LANES*ELEM_W-1:0] lane_result,
   mxv_lane_scheduler_if.master        out_if,
   output logic                        busy,
   output logic                        finish
`ifdef MXV_PROTOCOL_CHK_EN
   ,
   output logic                        proto_err
`endif
);

   localparam int unsigned CW1 = CNT_W + 1;

   typedef enum logic [2:0] {
      IDLE, FETCH, WAIT_MEM, ISSUE, RUN, DRAIN, DONE
   } state_t;

   state_t                      state, state_next;
   logic [CNT_W-1:0]            rows_q;
   logic [CNT_W-1:0]            row_base;
   logic [NUM_LANES-1:0]        act_mask;
   logic [NUM_LANES-1:0]        done_mask;
   logic [NUM_LANES*ELEM_W-1:0] cap;

   logic [CW1-1:0]              remaining;
   logic [CW1-1:0]              next_base;
   logic                        more_groups;
   logic [NUM_LANES-1:0]        act_comb;
   logic [NUM_LANES-1:0]        new_done;
   logic [NUM_LANES-1:0]        next_mask;
   logic                        out_valid;

   // Rows left from this group's base; lane k is active iff k < remaining.
   // Another group exists iff base+NUM_LANES < total_rows, which is the
   // g+1 < ceil(total_rows/NUM_LANES) test without a divider.
   assign remaining   = {1'b0, rows_q} - {1'b0, row_base};
   assign next_base   = {1'b0, row_base} + CW1'(NUM_LANES);
   assign more_groups = next_base < {1'b0, rows_q};

   always_comb begin
      act_comb = '0;
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
         act_comb[k] = CW1'(k) < remaining;
      end
   end

   assign new_done  = lane_done & act_mask & ~done_mask;
   assign next_mask = done_mask | new_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      mem_fetch  = 1'b0;
      lane_start = '0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = (total_rows == '0) ? DONE : FETCH;
         end
         FETCH: begin
            busy       = 1'b1;
            mem_fetch  = 1'b1;
            state_next = WAIT_MEM;
         end
         WAIT_MEM: begin
            busy = 1'b1;
            if (mem_ready) state_next = ISSUE;
         end
         ISSUE: begin
            busy       = 1'b1;
            lane_start = act_comb;
            state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            // Exit on the capturing edge so out_valid rises the next cycle.
            if (next_mask == act_mask) state_next = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_if.out_ready) state_next = more_groups ? FETCH : DONE;
         end
         DONE: begin
            finish = 1'b1;
         end
         default: state_next = IDLE;
      endcase
      if (!start) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rows_q         <= '0;
         lane_multiples <= '0;
         row_base       <= '0;
         act_mask       <= '0;
         done_mask      <= '0;
         cap            <= '0;
      end else if (!start) begin
         // Abort: discard any partially captured group.
         row_base  <= '0;
         act_mask  <= '0;
         done_mask <= '0;
         cap       <= '0;
      end else begin
         case (state)
            IDLE: begin
               rows_q         <= total_rows;
               lane_multiples <= no_of_multiples;
               row_base       <= '0;
            end
            ISSUE: begin
               act_mask  <= act_comb;
               done_mask <= '0;
               cap       <= '0;
            end
            RUN: begin
               done_mask <= next_mask;
               for (int unsigned k = 0; k < NUM_LANES; k++) begin
                  if (new_done[k]) cap[k*ELEM_W +: ELEM_W] <= lane_result[k*ELEM_W +: ELEM_W];
               end
            end
            DRAIN: begin
               if (out_if.out_ready) row_base <= next_base[CNT_W-1:0];
            end
            default: ;
         endcase
      end
   end

   assign out_if.out_valid   = out_valid;
   assign out_if.out_data    = cap;
   assign out_if.out_row_idx = row_base;

`ifdef MXV_PROTOCOL_CHK_EN
   logic proto_evt;

   always_comb begin
      proto_evt = 1'b0;
      if (state == RUN) proto_evt = |(lane_done & ~(act_mask & ~done_mask));
      else              proto_evt = |lane_done;
      if (mem_ready && (state != WAIT_MEM)) proto_evt = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                        proto_err <= 1'b0;
      else if ((state != IDLE) && (state_next == IDLE)) proto_err <= 1'b0;
      else if (proto_evt)                                proto_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_mxv_lane_scheduler.sv
// Directed bench for mxv_lane_scheduler (NUM_LANES=4, ELEM_W=32, CNT_W=32).
// Expected groups are queued when lane results are driven and popped when
// the scheduler presents out_valid.
module tb_mxv_lane_scheduler;
   localparam int unsigned EW = 32;
   localparam int unsigned NL = 4;
   localparam int unsigned CW = 32;
   localparam int unsigned DW = NL*EW;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [CW-1:0] row;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [CW-1:0] total_rows;
   logic [CW-1:0] no_of_multiples;
   logic [CW-1:0] lane_multiples;
   logic          mem_fetch;
   logic          mem_ready;
   logic [NL-1:0] lane_start;
   logic [NL-1:0] lane_done;
   logic [DW-1:0] lane_result;
   logic          busy;
   logic          finish;
`ifdef MXV_PROTOCOL_CHK_EN
   logic          proto_err;
`endif

   mxv_lane_scheduler_if #(.ELEM_W(EW), .NUM_LANES(NL), .CNT_W(CW)) oif ();

   mxv_lane_scheduler #(.ELEM_W(EW), .NUM_LANES(NL), .CNT_W(CW)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .total_rows      (total_rows),
      .no_of_multiples (no_of_multiples),
      .lane_multiples  (lane_multiples),
      .mem_fetch       (mem_fetch),
      .mem_ready       (mem_ready),
      .lane_start      (lane_start),
      .lane_done       (lane_done),
      .lane_result     (lane_result),
      .out_if          (oif),
      .busy            (busy),
      .finish          (finish)
`ifdef MXV_PROTOCOL_CHK_EN
      ,
      .proto_err       (proto_err)
`endif
   );

   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   int   fetch_cnt = 0;
   int   issue_cnt = 0;
   int   f0, i0;
   exp_t sb[$];
   exp_t e;

   always @(negedge clk) begin
      if (mem_fetch === 1'b1)  fetch_cnt <= fetch_cnt + 1;
      if (lane_start != '0)    issue_cnt <= issue_cnt + 1;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] zfill(input logic [DW-1:0] d, input logic [NL-1:0] m);
      logic [DW-1:0] r;
      r = d;
      for (int k = 0; k < int'(NL); k++) if (!m[k]) r[k*EW +: EW] = '0;
      return r;
   endfunction

   // Waits for the fetch pulse, answers it, checks the issue pulse; returns in RUN.
   task automatic issue_group(input logic [NL-1:0] exp_mask);
      int n;
      n = 0;
      while (mem_fetch !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("mem_fetch_seen", mem_fetch, 1);
      @(negedge clk);
      chk("mem_fetch_one_cycle", mem_fetch, 0);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("lane_start", lane_start, exp_mask);
      chk("busy_issue", busy, 1);
      @(negedge clk);
      chk("lane_start_one_cycle", lane_start, 0);
   endtask

   task automatic pulse_done(input logic [NL-1:0] m, input logic [DW-1:0] r);
      lane_done   = m;
      lane_result = r;
      @(negedge clk);
      lane_done   = '0;
      lane_result = '0;
   endtask

   task automatic drain(input int hold);
      exp_t x;
      chk("out_valid_rise", oif.out_valid, 1);
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL sb_empty observed=0 expected=1");
         return;
      end
      x = sb.pop_front();
      chk("out_data", oif.out_data, x.data);
      chk("out_row_idx", oif.out_row_idx, x.row);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", oif.out_valid, 1);
         chk("hold_data", oif.out_data, x.data);
         chk("hold_no_fetch", mem_fetch, 0);
      end
      oif.out_ready = 1'b1;
      @(negedge clk);
      oif.out_ready = 1'b0;
      chk("out_valid_drop", oif.out_valid, 0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; total_rows = '0; no_of_multiples = '0;
      mem_ready = 1'b0; lane_done = '0; lane_result = '0; oif.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_finish", finish, 0);
      chk("rst_valid", oif.out_valid, 0);
      chk("rst_fetch", mem_fetch, 0);
      chk("rst_lane_start", lane_start, 0);
      chk("rst_data", oif.out_data, 0);
      chk("rst_row", oif.out_row_idx, 0);
      chk("rst_mult", lane_multiples, 0);
      reset = 1'b1;
      @(negedge clk);

      // 8 rows, all lanes done together
      f0 = fetch_cnt; i0 = issue_cnt;
      total_rows = 8; no_of_multiples = 3; start = 1'b1;
      @(negedge clk);
      chk("lane_multiples", lane_multiples, 3);
      issue_group(4'b1111);
      e.data = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100}; e.row = 0;
      sb.push_back(e);
      pulse_done(4'b1111, e.data);
      drain(0);
      issue_group(4'b1111);
      e.data = {32'hA4, 32'hA3, 32'hA2, 32'hA1}; e.row = 4;
      sb.push_back(e);
      pulse_done(4'b1111, e.data);
      drain(0);
      chk("t1_finish", finish, 1);
      chk("t1_busy", busy, 0);
      chk("t1_fetches", fetch_cnt - f0, 2);
      chk("t1_issues", issue_cnt - i0, 2);
      start = 1'b0;
      @(negedge clk);
      chk("t1_finish_clear", finish, 0);

      // 6 rows: partial second group, inactive lanes also pulse done
      f0 = fetch_cnt;
      total_rows = 6; start = 1'b1;
      @(negedge clk);
      issue_group(4'b1111);
      e.data = {32'h4, 32'h3, 32'h2, 32'h1}; e.row = 0;
      sb.push_back(e);
      pulse_done(4'b1111, e.data);
      drain(0);
      issue_group(4'b0011);
      e.data = zfill({32'hAAAA, 32'hBBBB, 32'h11, 32'h22}, 4'b0011); e.row = 4;
      sb.push_back(e);
      pulse_done(4'b1111, {32'hAAAA, 32'hBBBB, 32'h11, 32'h22});
      drain(0);
      chk("t2_finish", finish, 1);
      chk("t2_fetches", fetch_cnt - f0, 2);
      start = 1'b0;
      @(negedge clk);

      // Out-of-order dones, duplicate on lane0, 5-cycle backpressure
      total_rows = 4; start = 1'b1;
      @(negedge clk);
      issue_group(4'b1111);
      e.data = {32'h30, 32'h20, 32'h10, 32'h00}; e.row = 0;
      pulse_done(4'b1000, {32'h30, 32'hDEAD, 32'hDEAD, 32'hDEAD});
      chk("t3_wait1", oif.out_valid, 0);
      pulse_done(4'b0001, {32'hDEAD, 32'hDEAD, 32'hDEAD, 32'h00});
      pulse_done(4'b0100, {32'hDEAD, 32'h20, 32'hDEAD, 32'hDEAD});
      pulse_done(4'b0001, {32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hFF});
      chk("t3_wait_dup", oif.out_valid, 0);
      sb.push_back(e);
      pulse_done(4'b0010, {32'hDEAD, 32'hDEAD, 32'h10, 32'hDEAD});
`ifdef MXV_PROTOCOL_CHK_EN
      chk("t3_proto_err", proto_err, 1);
`endif
      drain(5);
      chk("t3_finish", finish, 1);
      start = 1'b0;
      @(negedge clk);

      // Abort mid-RUN of group 1, then a clean 4-row job
      total_rows = 8; start = 1'b1;
      @(negedge clk);
      issue_group(4'b1111);
      e.data = {32'h7, 32'h6, 32'h5, 32'h4}; e.row = 0;
      sb.push_back(e);
      pulse_done(4'b1111, e.data);
      drain(0);
      issue_group(4'b1111);
      pulse_done(4'b0001, {32'h0, 32'h0, 32'h0, 32'h99});
      start = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_valid", oif.out_valid, 0);
      chk("abort_finish", finish, 0);
      @(negedge clk);
      chk("abort_valid2", oif.out_valid, 0);
      f0 = fetch_cnt;
      total_rows = 4; start = 1'b1;
      @(negedge clk);
      issue_group(4'b1111);
      e.data = {32'hB3, 32'hB2, 32'hB1, 32'hB0}; e.row = 0;
      sb.push_back(e);
      pulse_done(4'b1111, e.data);
      drain(0);
      chk("restart_finish", finish, 1);
      chk("restart_fetches", fetch_cnt - f0, 1);
      start = 1'b0;
      @(negedge clk);

      // Zero rows
      f0 = fetch_cnt;
      total_rows = 0; start = 1'b1;
      @(negedge clk);
      chk("zero_finish", finish, 1);
      chk("zero_busy", busy, 0);
      @(negedge clk);
      chk("zero_finish_held", finish, 1);
      chk("zero_fetches", fetch_cnt - f0, 0);
      start = 1'b0;
      @(negedge clk);
      chk("zero_finish_clear", finish, 0);

      // Asynchronous reset while in DRAIN
      total_rows = 4; no_of_multiples = 7; start = 1'b1;
      @(negedge clk);
      issue_group(4'b1111);
      e.data = {32'hC3, 32'hC2, 32'hC1, 32'hC0}; e.row = 0;
      pulse_done(4'b1111, e.data);
      chk("ar_valid_before", oif.out_valid, 1);
      chk("ar_data_before", oif.out_data, e.data);
      chk("ar_mult_before", lane_multiples, 7);
      #2 reset = 1'b0;
      #1;
      chk("ar_valid", oif.out_valid, 0);
      chk("ar_data", oif.out_data, 0);
      chk("ar_mult", lane_multiples, 0);
      chk("ar_busy", busy, 0);
      chk("ar_finish", finish, 0);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
